// File: rtl/conv_window_feeder.sv
// Line-buffered column feeder: turns a raster pixel stream into K_H-pixel
// column vectors for the conv datapath, flagging columns that close a window.
module conv_window_feeder #(
   parameter int IMG_H = 16,
   parameter int IMG_W = 15,
   parameter int K_H   = 3,
   parameter int K_W   = 3,
   parameter int DW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DW-1:0]     in_pix,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [K_H*DW-1:0] out_col,
   output logic              out_win,
   output logic              out_row_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              frame_done
);

   // state    | meaning
   // S_IDLE   | waiting for start, nothing accepted
   // S_FILL   | loading rows 0..K_H-2 into the line buffers, no output
   // S_STREAM | each accepted pixel produces one column vector
   // S_DRAIN  | last pixel taken, waiting for the final column to be popped
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DRAIN} state_t;

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_WIN       = CW'(K_W - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K_H - 2);

   state_t                state;
   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [CW-1:0]         col_nxt;
   logic [RW-1:0]         row_nxt;
   logic [DW-1:0]         lb [K_H-1][IMG_W];
   logic [K_H*DW-1:0]     col_vec;
   logic                  accept;
   logic                  pop;
   logic                  at_col_last;

   always_comb begin
      in_ready = 1'b0;
      case (state)
         S_FILL:   in_ready = 1'b1;
         S_STREAM: in_ready = out_ready | ~out_valid;
         default:  in_ready = 1'b0;
      endcase
   end

   assign busy        = (state != S_IDLE);
   assign accept      = in_valid & in_ready;
   assign pop         = out_valid & out_ready;
   assign at_col_last = (col == COL_LAST);

   always_comb begin
      col_nxt = col + 1'b1;
      row_nxt = row;
      if (at_col_last) begin
         col_nxt = '0;
         row_nxt = row + 1'b1;
      end
   end

   // Oldest buffered row lands in the low slice, the live pixel in the top one.
   always_comb begin
      col_vec = '0;
      for (int k = 0; k < K_H-1; k++) begin
         col_vec[k*DW +: DW] = lb[k][col];
      end
      col_vec[(K_H-1)*DW +: DW] = in_pix;
   end

   // Buffers shift one row per accepted pixel in both FILL and STREAM, so the
   // fill phase fully overwrites anything left over from a previous frame.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < K_H-2; k++) begin
            lb[k][col] <= lb[k+1][col];
         end
         lb[K_H-2][col] <= in_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         col          <= '0;
         row          <= '0;
         out_col      <= '0;
         out_win      <= 1'b0;
         out_row_last <= 1'b0;
         out_valid    <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_FILL;
                  col   <= '0;
                  row   <= '0;
               end
            end
            S_FILL: begin
               if (accept) begin
                  col <= col_nxt;
                  row <= row_nxt;
                  if (at_col_last && row == ROW_FILL_LAST) state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (pop) out_valid <= 1'b0;
               if (accept) begin
                  out_valid    <= 1'b1;
                  out_col      <= col_vec;
                  out_win      <= (col >= COL_WIN);
                  out_row_last <= at_col_last;
                  col          <= col_nxt;
                  row          <= row_nxt;
                  if (at_col_last && row == ROW_LAST) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop) begin
                  out_valid  <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomized bench for conv_window_feeder: a queue of expected columns is
// built from the pixel formula and compared against every popped column.
module tb_conv_window_feeder;

   localparam int IMG_H = 16;
   localparam int IMG_W = 15;
   localparam int K_H   = 3;
   localparam int K_W   = 3;
   localparam int DW    = 8;

   typedef struct {
      logic [K_H*DW-1:0] col;
      logic              win;
      logic              last;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [DW-1:0]     in_pix;
   logic              in_valid;
   logic              in_ready;
   logic [K_H*DW-1:0] out_col;
   logic              out_win;
   logic              out_row_last;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              frame_done;

   int   n_chk = 0;
   int   n_err = 0;
   int   rdy_pct = 100;
   bit   mon_en = 1'b0;
   bit   cur_inv = 1'b0;
   exp_t q[$];
   int   n_col, n_win, done_cnt = 0;
   bit   exp_done = 1'b0;
   bit   prev_stall = 1'b0;
   logic [K_H*DW-1:0] prev_col;
   logic prev_win, prev_last;

   conv_window_feeder #(.IMG_H(IMG_H), .IMG_W(IMG_W), .K_H(K_H), .K_W(K_W), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_pix(in_pix), .in_valid(in_valid),
      .in_ready(in_ready), .out_col(out_col), .out_win(out_win),
      .out_row_last(out_row_last), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int r, input int c, input bit inv);
      int v;
      v = r*16 + c;
      if (inv) v = 255 - v;
      return DW'(v);
   endfunction

   always @(posedge clk) begin
      #1;
      out_ready = ($urandom_range(99) < rdy_pct);
   end

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (frame_done || exp_done) chk("frame_done", 32'(frame_done), 32'(exp_done));
         if (frame_done) done_cnt++;
         exp_done = 1'b0;
         if (prev_stall) begin
            chk("stall_col", 32'(out_col), 32'(prev_col));
            chk("stall_win", 32'(out_win), 32'(prev_win));
            chk("stall_last", 32'(out_row_last), 32'(prev_last));
         end
         if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            chk("col_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               chk("col", 32'(out_col), 32'(e.col));
               chk("win", 32'(out_win), 32'(e.win));
               chk("row_last", 32'(out_row_last), 32'(e.last));
               n_col++;
               if (out_win) n_win++;
               if (n_col == 1)
                  chk("first_col", 32'(out_col), cur_inv ? 32'hDFEFFF : 32'h201000);
               if (q.size() == 0) begin
                  exp_done = 1'b1;
                  if (!cur_inv) chk("last_col", 32'(out_col), 32'hFEEEDE);
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_col   = out_col;
         prev_win   = out_win;
         prev_last  = out_row_last;
      end
   end

   task automatic run_frame(input bit inv, input int gap_pct, input int mid_start, input int stop_at);
      int  idx = 0;
      int  budget = 20000;
      int  n = 0;
      int  d0;
      bit  acc;
      cur_inv = inv;
      n_col = 0;
      n_win = 0;
      q.delete();
      for (int r = K_H-1; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            exp_t e;
            e.col  = {pix(r, c, inv), pix(r-1, c, inv), pix(r-2, c, inv)};
            e.win  = (c >= K_W-1);
            e.last = (c == IMG_W-1);
            q.push_back(e);
         end
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      while (idx < IMG_H*IMG_W && budget > 0) begin
         in_valid = ($urandom_range(99) >= gap_pct);
         in_pix   = in_valid ? pix(idx / IMG_W, idx % IMG_W, inv) : DW'($urandom);
         start    = (idx == mid_start);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         budget--;
         start = 1'b0;
         if (acc) begin
            idx++;
            if (idx == (K_H-1)*IMG_W) begin
               chk("fill_no_out", 32'(out_valid), 32'd0);
               chk("fill_no_cols", 32'(n_col), 32'd0);
            end
            if (idx == (K_H-1)*IMG_W + 1) chk("first_latency", 32'(out_valid), 32'd1);
         end
         if (stop_at >= 0 && idx == stop_at) break;
      end
      in_valid = 1'b0;
      if (stop_at < 0) begin
         chk("pixels_accepted", 32'(idx), 32'(IMG_H*IMG_W));
         d0 = done_cnt;
         while (done_cnt == d0 && n < 500) begin
            @(posedge clk);
            n++;
         end
         #1;
         chk("frame_done_count", 32'(done_cnt - d0), 32'd1);
         chk("frame_cols", 32'(n_col), 32'((IMG_H-K_H+1)*IMG_W));
         chk("frame_wins", 32'(n_win), 32'((IMG_H-K_H+1)*(IMG_W-K_W+1)));
         chk("idle_after_frame", 32'(busy), 32'd0);
         chk("queue_drained", 32'(q.size()), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pix = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_col", 32'(out_col), 32'd0);
      chk("rst_out_win", 32'(out_win), 32'd0);
      chk("rst_row_last", 32'(out_row_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      rdy_pct = 100; run_frame(1'b0, 0, -1, -1);
      rdy_pct = 50;  run_frame(1'b0, 0, -1, -1);
      rdy_pct = 100; run_frame(1'b0, 40, -1, -1);
      rdy_pct = 70;  run_frame(1'b0, 20, 50, -1);

      rdy_pct = 100; run_frame(1'b0, 0, -1, 100);
      mon_en = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      q.delete();
      prev_stall = 1'b0;
      exp_done = 1'b0;
      mon_en = 1'b1;
      run_frame(1'b0, 0, -1, -1);

      run_frame(1'b0, 0, -1, -1);
      rdy_pct = 60;
      run_frame(1'b1, 10, -1, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Upstream stage of the NPU conv datapath.
- Accepts a raster-order 8-bit pixel stream (IMG_H x IMG_W) and buffers K_H-1 previous rows in line buffers.
- Emits one K_H-pixel column vector per accepted pixel once K_H-1 rows are buffered. Packing matches the NPU image-load word: row r-2 in [7:0], r-1 in [15:8], r in [23:16].
- Flags columns that complete a full K_H x K_W window, so the controller can pulse the conv trigger.

Parameters:
- IMG_H, 16, image rows
- IMG_W, 15, image columns (line buffer depth)
- K_H, 3, kernel rows (number of pixels per output column)
- K_W, 3, kernel columns (column index from which windows are complete)
- DW, 8, pixel width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a frame; ignored unless in S_IDLE
- in_pix  in  DW  pixel, unsigned
- in_valid  in  1  pixel valid
- in_ready  out  1  feeder can accept pixel
- out_col  out  K_H*DW  column vector; slice k = row r-(K_H-1)+k, same column
- out_win  out  1  column completes a window (col >= K_W-1)
- out_row_last  out  1  column is col IMG_W-1
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accepts
- busy  out  1  state != S_IDLE
- frame_done  out  1  one-cycle pulse after last column accepted

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_col=0, out_win=0, out_row_last=0, busy=0, frame_done=0. Row/col counters=0, state=S_IDLE. Line buffer contents are don't-care and need no reset.
- Reset is synchronous and overrides everything, including mid-frame. Any in-flight output is dropped and the next frame must be started with start.
- States:
  - S_IDLE: in_ready=0. start -> S_FILL, counters cleared.
  - S_FILL (rows 0..K_H-2): in_ready=1. Each accepted pixel is written to the line buffers; no output. Accepting col IMG_W-1 of row K_H-2 -> S_STREAM.
  - S_STREAM (rows K_H-1..IMG_H-1): in_ready = out_ready | ~out_valid. Accepting the pixel at (r,c) loads the output register next cycle:
    - out_col = {in_pix, lb[K_H-2][c], ..., lb[0][c]}, where lb[0] is the oldest row.
    - out_win = (c >= K_W-1); out_row_last = (c == IMG_W-1); out_valid=1.
    - Line buffers shift at column c: lb[k][c] <= lb[k+1][c]; the newest buffer takes in_pix.
    - Accepting pixel (IMG_H-1, IMG_W-1) -> S_DRAIN.
  - S_DRAIN: in_ready=0. When out_valid & out_ready: out_valid=0, frame_done=1 for one cycle, -> S_IDLE.
- Latency: 1 cycle from pixel acceptance to out_valid.
- out_valid & ~out_ready holds out_col/out_win/out_row_last stable; no pixel is accepted (in_ready=0). A simultaneous accept and pop in the same cycle is allowed and sustains 1 column/cycle.
- Column counter wraps IMG_W-1 -> 0 with a row increment. The row counter is not used past IMG_H-1.
- Per frame: (IMG_H-K_H+1)*IMG_W columns out, (IMG_H-K_H+1)*(IMG_W-K_W+1) with out_win=1.
- No arithmetic on pixel data; pure routing and storage.
- start asserted while busy has no effect.
- in_pix is ignored whenever in_ready=0.

Test Plan:
- Reset, start, full frame with pixel value = r*16+c, out_ready=1 -> first out_col=0x201000 (r0c0,r1c0,r2c0) with out_win=0. The third column is 0x221202 with out_win=1. Exactly 210 out_valid cycles, 182 with out_win=1. frame_done pulses once, one cycle after the last column (0xFEEEDE) is accepted.
- Random out_ready deassertion (50%) during streaming -> output sequence identical to the first scenario. out_col is stable while stalled. in_ready=0 on every cycle with out_valid & ~out_ready.
- Random in_valid gaps -> same 210-column sequence. No duplicated or skipped columns. S_FILL consumes exactly 30 pixels with no output.
- start pulsed mid-frame (after 50 pixels) -> ignored; output sequence unchanged.
- rst asserted after 100 pixels with out_valid=1 -> next cycle out_valid=0, in_ready=0, busy=0. A fresh start plus a full frame reproduces the first scenario exactly.
- Two back-to-back frames, second with pixel = 255-(r*16+c) -> second frame's first out_col=0xDFEFFF. No contamination from frame 1 line buffer contents.
